// File: rtl/lock_code_sender.sv
// lock_code_sender: replays a captured binary code as timed btn_0/btn_1 level presses.
// Ports: clk, btn_reset (sync, active-high), start, code[CODE_LEN-1:0] (MSB sent first), unlock;
//        btn_0, btn_1, lock_reset, busy, done, fail (all registered).
// Define LOCK_SENDER_RETRY_EN to wait for unlock after each attempt and resend on timeout.
module lock_code_sender #(
  parameter int CODE_LEN       = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int MAX_RETRY      = 2
) (
  input  logic                clk,
  input  logic                btn_reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                unlock,
  output logic                btn_0,
  output logic                btn_1,
  output logic                lock_reset,
  output logic                busy,
  output logic                done,
  output logic                fail
);
  localparam int MHG = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MX  = MHG > TIMEOUT_CYCLES ? MHG : TIMEOUT_CYCLES;
  localparam int CW  = $clog2(MX + 1);
  localparam int DW  = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam logic [CW-1:0] HL = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GL = CW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DL = DW'(CODE_LEN - 1);
  typedef enum logic [2:0] {
    IDLE, PRESS, RELEASE, DONE
`ifdef LOCK_SENDER_RETRY_EN
    , CHECK
`endif
  } state_t;
  state_t st, st_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [DW-1:0] dig, dig_d;
  logic [CODE_LEN-1:0] sr, sr_d;
  logic btn_0_d, btn_1_d, busy_d, done_d;
`ifdef LOCK_SENDER_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] TL = CW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RL = RW'(MAX_RETRY);
  logic [CODE_LEN-1:0] cap, cap_d;
  logic [RW-1:0] rty, rty_d;
  logic lock_reset_d, fail_d;
`else
  logic unused_unlock;
  assign unused_unlock = unlock;
  assign lock_reset = 1'b0;
  assign fail = 1'b0;
`endif
  always_comb begin
    st_d = st;
    cnt_d = cnt;
    dig_d = dig;
    sr_d = sr;
`ifdef LOCK_SENDER_RETRY_EN
    cap_d = cap;
    rty_d = rty;
`endif
    case (st)
      IDLE: if (start) begin
        st_d = PRESS;
        cnt_d = '0;
        dig_d = '0;
        sr_d = code;
`ifdef LOCK_SENDER_RETRY_EN
        cap_d = code;
        rty_d = '0;
`endif
      end
      PRESS: begin
        st_d = cnt == HL ? RELEASE : PRESS;
        cnt_d = cnt == HL ? '0 : cnt + 1'b1;
      end
      RELEASE: if (cnt != GL) cnt_d = cnt + 1'b1;
      else begin
        cnt_d = '0;
        if (dig == DL)
`ifdef LOCK_SENDER_RETRY_EN
          st_d = CHECK;
`else
          st_d = DONE;
`endif
        else begin
          st_d = PRESS;
          dig_d = dig + 1'b1;
          sr_d = sr << 1;
        end
      end
      DONE: st_d = IDLE;
`ifdef LOCK_SENDER_RETRY_EN
      // cnt == TL is the extra cycle that carries the lock_reset pulse
      CHECK: if (cnt == TL) begin
        cnt_d = '0;
        if (rty < RL) begin
          rty_d = rty + 1'b1;
          st_d = PRESS;
          dig_d = '0;
          sr_d = cap;
        end else st_d = IDLE;
      end else if (unlock) begin
        st_d = DONE;
        cnt_d = '0;
      end else cnt_d = cnt + 1'b1;
`endif
      default: st_d = IDLE;
    endcase
    btn_1_d = st_d == PRESS && sr_d[CODE_LEN-1];
    btn_0_d = st_d == PRESS && !sr_d[CODE_LEN-1];
    busy_d = st_d != IDLE;
    done_d = st_d == DONE;
`ifdef LOCK_SENDER_RETRY_EN
    lock_reset_d = st_d == CHECK && cnt_d == TL;
    fail_d = lock_reset_d && rty_d == RL;
`endif
  end
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      st <= IDLE;
      cnt <= '0;
      dig <= '0;
      sr <= '0;
      btn_0 <= 1'b0;
      btn_1 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_d;
      cnt <= cnt_d;
      dig <= dig_d;
      sr <= sr_d;
      btn_0 <= btn_0_d;
      btn_1 <= btn_1_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
`ifdef LOCK_SENDER_RETRY_EN
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      cap <= '0;
      rty <= '0;
      lock_reset <= 1'b0;
      fail <= 1'b0;
    end else begin
      cap <= cap_d;
      rty <= rty_d;
      lock_reset <= lock_reset_d;
      fail <= fail_d;
    end
  end
`endif
endmodule

// File: tb/tb_lock_code_sender.sv
// tb_lock_code_sender: randomized trace comparison of lock_code_sender against a per-cycle output model.
module tb_lock_code_sender;
  localparam int CL = 4;
  localparam int H = 2;
  localparam int G = 2;
  localparam int T = 8;
  localparam int MR = 2;
  logic clk = 1'b0;
  logic btn_reset, start, unlock;
  logic [CL-1:0] code;
  logic btn_0, btn_1, lock_reset, busy, done, fail;
  logic [5:0] obs;
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int checks = 0;
  int errors = 0;
  assign obs = {btn_0, btn_1, busy, done, lock_reset, fail};
  lock_code_sender #(.CODE_LEN(CL), .HOLD_CYCLES(H), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .btn_reset(btn_reset), .start(start), .code(code), .unlock(unlock),
    .btn_0(btn_0), .btn_1(btn_1), .lock_reset(lock_reset), .busy(busy), .done(done), .fail(fail)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if ((btn_0 && btn_1) || (done && fail)) begin
      errors++;
      $display("FAIL exclusive_outputs t=%0t btn_0=%b btn_1=%b done=%b fail=%b, required no overlapping pair", $time, btn_0, btn_1, done, fail);
    end
  end
  // Expected {btn_0,btn_1,busy,done,lock_reset,fail} per cycle; index 0 is the start cycle, ua is the unlock cycle.
  function automatic void build_exp(input logic [CL-1:0] c, input int ua);
    exp_q.delete();
    exp_q.push_back(6'b000000);
    for (int a = 0; a <= MR; a++) begin
      for (int i = CL - 1; i >= 0; i--) begin
        repeat (H) exp_q.push_back({~c[i], c[i], 4'b1000});
        repeat (G) exp_q.push_back(6'b001000);
      end
`ifdef LOCK_SENDER_RETRY_EN
      for (int t = 0; t < T; t++) begin
        exp_q.push_back(6'b001000);
        if (int'(exp_q.size()) - 1 == ua) begin
          exp_q.push_back(6'b001100);
          return;
        end
      end
      exp_q.push_back(a == MR ? 6'b001011 : 6'b001010);
      if (a == MR) return;
`else
      exp_q.push_back(6'b001100);
      return;
`endif
    end
  endfunction
  task automatic run_trace(input logic [CL-1:0] c, input int ua, input int s2, input logic [CL-1:0] c2);
    obs_q.delete();
    for (int cyc = 0; cyc < exp_q.size(); cyc++) begin
      start = cyc == 0 || cyc == s2;
      code = cyc == 0 ? c : cyc == s2 ? c2 : CL'($urandom);
      unlock = cyc == ua;
      @(negedge clk);
      obs_q.push_back(obs);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    unlock = 1'b0;
  endtask
  task automatic test_reset();
    btn_reset = 1'b1;
    start = 1'b1;
    code = CL'($urandom);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 000000", obs);
    end
    @(posedge clk);
    #1;
    btn_reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b required 000000", obs);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    int ua, dc;
`ifdef LOCK_SENDER_RETRY_EN
    ua = 17;
    dc = 18;
`else
    ua = -1;
    dc = 17;
`endif
    build_exp(4'b1011, ua);
    run_trace(4'b1011, ua, -1, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic cycle %0d got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[dc][2] !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_cycle cycle %0d done=%b required 1", dc, obs_q[dc][2]);
    end
  endtask
  task automatic test_ignore_start();
    int ua;
`ifdef LOCK_SENDER_RETRY_EN
    ua = 17;
`else
    ua = -1;
`endif
    build_exp(4'b1011, ua);
    run_trace(4'b1011, ua, 6, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_start cycle %0d got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_random();
    repeat (6) begin
      logic [CL-1:0] c;
      int ua;
      c = CL'($urandom);
      ua = $urandom_range(40, 0);
      build_exp(c, ua);
      run_trace(c, ua, $urandom_range(20, 2), CL'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random code %b unlock@%0d cycle %0d got %b required %b", c, ua, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    repeat (2) begin
      logic [CL-1:0] c;
      c = CL'($urandom);
      build_exp(c, 17);
      run_trace(c, 17, -1, 4'b0000);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL back_to_back code %b cycle %0d got %b required %b", c, i, obs_q[i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL back_to_back_idle got %b required 000000", obs);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_abort();
    logic [CL-1:0] c;
    c = CL'($urandom);
    build_exp(c, -1);
    for (int cyc = 0; cyc < 8; cyc++) begin
      start = cyc == 0;
      btn_reset = cyc == 5;
      code = CL'($urandom);
      if (cyc == 0) code = c;
      @(negedge clk);
      checks++;
      if (obs !== (cyc <= 5 ? exp_q[cyc] : 6'b0)) begin
        errors++;
        $display("FAIL abort cycle %0d got %b required %b", cyc, obs, cyc <= 5 ? exp_q[cyc] : 6'b0);
      end
      @(posedge clk);
      #1;
    end
    btn_reset = 1'b0;
    c = CL'($urandom);
    build_exp(c, 20);
    run_trace(c, 20, -1, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL after_abort code %b cycle %0d got %b required %b", c, i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`ifdef LOCK_SENDER_RETRY_EN
  task automatic test_retry_unlock();
    int lr;
    lr = 0;
    build_exp(4'b1011, 20);
    run_trace(4'b1011, 20, -1, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      lr += int'(obs_q[i][1]);
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL retry_unlock cycle %0d got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (lr !== 0) begin
      errors++;
      $display("FAIL retry_unlock_lock_reset count %0d required 0", lr);
    end
  endtask
  task automatic test_retry_exhaust();
    logic [CL-1:0] c;
    int lr, fl;
    lr = 0;
    fl = 0;
    c = CL'($urandom);
    build_exp(c, -1);
    run_trace(c, -1, -1, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      lr += int'(obs_q[i][1]);
      fl += int'(obs_q[i][0]);
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL retry_exhaust cycle %0d got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (lr !== MR + 1 || fl !== 1) begin
      errors++;
      $display("FAIL retry_exhaust_counts lock_reset %0d fail %0d required %0d and 1", lr, fl, MR + 1);
    end
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL retry_exhaust_idle got %b required 000000", obs);
    end
    @(posedge clk);
    #1;
  endtask
`endif
  initial begin
    btn_reset = 1'b0;
    start = 1'b0;
    unlock = 1'b0;
    code = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_abort();
`ifdef LOCK_SENDER_RETRY_EN
    test_retry_unlock();
    test_retry_exhaust();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
